arc_microsequencer: RTL and testbench

- Control-store address sequencer for the ARC microarchitecture.
- Consumes the 41-bit microword registered by the microcode ROM (ROM updates on CLK negedge) and produces the next 11-bit control-store address on CLK posedge.
- Selects among increment, conditional or unconditional jump, and opcode decode, using PSR flags and IR fields.
- Adds memory-wait stall, halt handling and a per-cycle execute strobe for the datapath.

---
 rtl/arc_microsequencer.sv | 138 +++++++++++++
 tb/tb_arc_microsequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/arc_microsequencer.sv
// arc_microsequencer: control-store address sequencer for the ARC microarchitecture.
// Evaluates the microword presented by the ROM each posedge and selects the next
// control-store address (increment, conditional/unconditional jump, opcode decode).
// It also handles memory-wait stalls and halt requests, and drives a per-cycle
// execute strobe for the datapath.
module arc_microsequencer #(
  parameter int MI_W       = 41,
  parameter int ADDR_W     = 11,
  parameter int RESET_ADDR = 0
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic [MI_W-1:0]   MI_IN,
  input  logic [1:0]        IR_OP,
  input  logic [5:0]        IR_OP3,
  input  logic              IR_B13,
  input  logic              PSR_N,
  input  logic              PSR_Z,
  input  logic              PSR_V,
  input  logic              PSR_C,
  input  logic              MEM_ACK,
  input  logic              HALT_REQ,
  output logic [ADDR_W-1:0] CS_ADDR,
  output logic              EXEC,
  output logic              STALL,
  output logic              HALTED
);

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_WAIT  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_ADDR);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cs_addr_reg, cs_addr_next;
  logic                stall_reg, halted_reg;

  // Microword fields that affect sequencing; everything else is datapath-only.
  logic                mi_rd, mi_wr;
  logic [2:0]          mi_cond;
  logic [ADDR_W-1:0]   mi_jaddr;
  logic                mem_op;
  logic [ADDR_W-1:0]   seq_addr;
  logic                take_jump;

  assign mi_rd    = MI_IN[19];
  assign mi_wr    = MI_IN[18];
  assign mi_cond  = MI_IN[13:11];
  assign mi_jaddr = MI_IN[10:0];
  assign mem_op   = mi_rd | mi_wr;

  // Address the current word would advance to if it commits now.
  always_comb begin
    take_jump = 1'b0;
    seq_addr  = cs_addr_reg + 1'b1;   // wraps modulo 2^ADDR_W
    case (mi_cond)
      3'b001:  take_jump = PSR_N;
      3'b010:  take_jump = PSR_Z;
      3'b011:  take_jump = PSR_V;
      3'b100:  take_jump = PSR_C;
      3'b101:  take_jump = IR_B13;
      3'b110:  take_jump = 1'b1;
      default: take_jump = 1'b0;
    endcase
    if (mi_cond == 3'b111) begin
      seq_addr = {1'b1, IR_OP, IR_OP3, 2'b00};
    end else if (take_jump) begin
      seq_addr = mi_jaddr;
    end
  end

  // Next-state, commit strobe and next address; a word commits only when it executes.
  always_comb begin
    state_next   = state_reg;
    cs_addr_next = cs_addr_reg;
    EXEC         = 1'b0;
    case (state_reg)
      S_RESET: begin
        state_next = S_RUN;
      end
      S_RUN: begin
        if (HALT_REQ) begin
          state_next = S_HALT;
        end else if (mem_op && !MEM_ACK) begin
          state_next = S_WAIT;
        end else begin
          EXEC         = 1'b1;
          cs_addr_next = seq_addr;
        end
      end
      S_WAIT: begin
        // A pending access must finish before a halt can be honoured.
        if (MEM_ACK) begin
          EXEC         = 1'b1;
          cs_addr_next = seq_addr;
          state_next   = S_RUN;
        end
      end
      S_HALT: begin
        // The held word is re-evaluated in S_RUN once the halt is released.
        if (!HALT_REQ) begin
          state_next = S_RUN;
        end
      end
      default: begin
        state_next = S_RESET;
      end
    endcase
  end

  // State, address and status flags; reset acts immediately in any state.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg   <= S_RESET;
      cs_addr_reg <= RESET_VAL;
      stall_reg   <= 1'b0;
      halted_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cs_addr_reg <= cs_addr_next;
      stall_reg   <= (state_next == S_WAIT);
      halted_reg  <= (state_next == S_HALT);
    end
  end

  assign CS_ADDR = cs_addr_reg;
  assign STALL   = stall_reg;
  assign HALTED  = halted_reg;

  // Datapath-only fields are not used by the sequencer.
  logic unused_fields;
  assign unused_fields = ^{MI_IN[MI_W-1:20], MI_IN[17:14]};

endmodule

// File: tb/tb_arc_microsequencer.sv
// tb_arc_microsequencer: directed-vector bench for arc_microsequencer.
// The bench plays the ROM by driving MI_IN directly between clock edges.
`timescale 1ns/1ps
module tb_arc_microsequencer;

  logic        clk;
  logic        reset_n;
  logic [40:0] mi_in;
  logic [1:0]  ir_op;
  logic [5:0]  ir_op3;
  logic        ir_b13;
  logic        psr_n, psr_z, psr_v, psr_c;
  logic        mem_ack;
  logic        halt_req;
  logic [10:0] cs_addr;
  logic        exec;
  logic        stall;
  logic        halted;

  int err_count;
  int chk_count;

  arc_microsequencer #(.MI_W(41), .ADDR_W(11), .RESET_ADDR(0)) dut (
    .CLK      (clk),
    .RESET_N  (reset_n),
    .MI_IN    (mi_in),
    .IR_OP    (ir_op),
    .IR_OP3   (ir_op3),
    .IR_B13   (ir_b13),
    .PSR_N    (psr_n),
    .PSR_Z    (psr_z),
    .PSR_V    (psr_v),
    .PSR_C    (psr_c),
    .MEM_ACK  (mem_ack),
    .HALT_REQ (halt_req),
    .CS_ADDR  (cs_addr),
    .EXEC     (exec),
    .STALL    (stall),
    .HALTED   (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    chk_count++;
    if (observed !== expected) begin
      err_count++;
      $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end else begin
      $display("ok   %s: %0d", tag, observed);
    end
  endtask

  // Present a microword; unused datapath fields carry a fixed nonzero pattern.
  task automatic drive_mi(input logic [2:0] cond, input logic [10:0] jaddr,
                          input logic rd, input logic wr);
    mi_in = {6'h2A, 1'b1, 6'h15, 1'b0, 6'h3F, 1'b1, rd, wr, 4'hA, cond, jaddr};
  endtask

  // Advance one posedge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Unconditional jump used to position the sequencer.
  task automatic goto_addr(input logic [10:0] a);
    drive_mi(3'b110, a, 1'b0, 1'b0);
    tick();
  endtask

  initial begin
    err_count = 0;
    chk_count = 0;
    reset_n  = 1'b0;
    ir_op    = 2'b00;
    ir_op3   = 6'b0;
    ir_b13   = 1'b0;
    psr_n    = 1'b0;
    psr_z    = 1'b0;
    psr_v    = 1'b0;
    psr_c    = 1'b0;
    mem_ack  = 1'b0;
    halt_req = 1'b0;
    drive_mi(3'b000, 11'd0, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    check("rst_addr", cs_addr, 0);
    check("rst_stall", stall, 0);
    check("rst_halted", halted, 0);
    check("rst_exec", exec, 0);

    // Release: address held one cycle, then increments
    reset_n = 1'b1;
    #1;
    check("sreset_exec", exec, 0);
    tick();
    check("sreset_hold", cs_addr, 0);
    check("run_exec", exec, 1);
    tick();
    check("inc_0_1", cs_addr, 1);

    // Opcode decode
    drive_mi(3'b111, 11'd0, 1'b0, 1'b0);
    ir_op = 2'b10; ir_op3 = 6'b010000;
    tick();
    check("decode_1600", cs_addr, 1600);
    ir_op3 = 6'b010001;
    tick();
    check("decode_1604", cs_addr, 1604);

    // Conditional on Z
    goto_addr(11'd5);
    check("goto_5", cs_addr, 5);
    psr_n = 1'b1; psr_v = 1'b1; psr_c = 1'b1; psr_z = 1'b0;
    drive_mi(3'b010, 11'd12, 1'b0, 1'b0);
    tick();
    check("z0_inc", cs_addr, 6);
    goto_addr(11'd5);
    psr_z = 1'b1;
    drive_mi(3'b010, 11'd12, 1'b0, 1'b0);
    tick();
    check("z1_jump", cs_addr, 12);

    // N, V, C conditions
    drive_mi(3'b001, 11'd100, 1'b0, 1'b0);
    tick();
    check("n1_jump", cs_addr, 100);
    psr_v = 1'b0;
    drive_mi(3'b011, 11'd700, 1'b0, 1'b0);
    tick();
    check("v0_inc", cs_addr, 101);
    drive_mi(3'b100, 11'd300, 1'b0, 1'b0);
    tick();
    check("c1_jump", cs_addr, 300);

    // IR_B13 condition and wrap
    ir_b13 = 1'b1;
    drive_mi(3'b101, 11'd2047, 1'b0, 1'b0);
    tick();
    check("b13_jump", cs_addr, 2047);
    drive_mi(3'b000, 11'd9, 1'b0, 1'b0);
    tick();
    check("wrap_0", cs_addr, 0);
    ir_b13 = 1'b0;
    drive_mi(3'b101, 11'd2047, 1'b0, 1'b0);
    tick();
    check("b13_inc", cs_addr, 1);

    // Unconditional jump with all flags clear
    psr_n = 1'b0; psr_z = 1'b0; psr_v = 1'b0; psr_c = 1'b0;
    drive_mi(3'b110, 11'd37, 1'b0, 1'b0);
    tick();
    check("jmp_37", cs_addr, 37);

    // Read stall, 3 cycles without ack, halt requested mid-wait
    drive_mi(3'b000, 11'd0, 1'b1, 1'b0);
    mem_ack = 1'b0;
    #1;
    check("stall_exec0", exec, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_addr", cs_addr, 37);
      check("stall_flag", stall, 1);
      check("stall_exec", exec, 0);
    end
    halt_req = 1'b1;
    mem_ack  = 1'b1;
    #1;
    check("ack_exec", exec, 1);
    tick();
    check("ack_addr", cs_addr, 38);
    check("ack_stall0", stall, 0);
    check("ack_nohalt", halted, 0);
    mem_ack = 1'b0;
    drive_mi(3'b000, 11'd0, 1'b0, 1'b0);
    #1;
    check("post_ack_halt_exec", exec, 0);
    tick();
    check("post_ack_halted", halted, 1);
    check("post_ack_hold", cs_addr, 38);
    halt_req = 1'b0;
    #1;
    check("unhalt_exec0", exec, 0);
    tick();
    check("unhalt_halted0", halted, 0);
    check("unhalt_hold", cs_addr, 38);
    tick();
    check("resume_39", cs_addr, 39);

    // Write with immediate ack does not stall; ack with no access is ignored
    drive_mi(3'b000, 11'd0, 1'b0, 1'b1);
    mem_ack = 1'b1;
    tick();
    check("wr_ack_addr", cs_addr, 40);
    check("wr_ack_stall", stall, 0);
    drive_mi(3'b000, 11'd0, 1'b0, 1'b0);
    tick();
    check("ack_noop_addr", cs_addr, 41);
    mem_ack = 1'b0;

    // Halt at address 20
    goto_addr(11'd20);
    halt_req = 1'b1;
    drive_mi(3'b110, 11'd500, 1'b0, 1'b0);
    #1;
    check("halt_exec0", exec, 0);
    tick();
    check("halt_flag", halted, 1);
    check("halt_addr", cs_addr, 20);
    tick();
    check("halt_hold", cs_addr, 20);
    check("halt_exec", exec, 0);
    halt_req = 1'b0;
    tick();
    check("release_halted0", halted, 0);
    check("release_addr", cs_addr, 20);
    check("release_exec", exec, 1);
    tick();
    check("held_word_jump", cs_addr, 500);
    drive_mi(3'b000, 11'd0, 1'b0, 1'b0);
    tick();
    check("continue_501", cs_addr, 501);

    // Asynchronous reset in the middle of a stall
    goto_addr(11'd37);
    drive_mi(3'b000, 11'd0, 1'b1, 1'b0);
    tick();
    check("pre_rst_stall", stall, 1);
    reset_n = 1'b0;
    #1;
    check("async_rst_addr", cs_addr, 0);
    check("async_rst_stall", stall, 0);
    check("async_rst_exec", exec, 0);
    tick();
    reset_n = 1'b1;
    drive_mi(3'b000, 11'd0, 1'b0, 1'b0);
    #1;
    check("rerst_exec0", exec, 0);
    tick();
    check("rerst_hold", cs_addr, 0);
    check("rerst_exec1", exec, 1);
    tick();
    check("rerst_inc", cs_addr, 1);

    $display("Result: errors=%0d of %0d checks", err_count, chk_count);
    $finish;
  end

endmodule
